// File: rtl/pid_share_arbiter.sv
// Round-robin arbiter that time-shares one pid_ctrl core among NUM_CH motor channels.
// Optional completion watchdog: define PID_ARB_TIMEOUT_EN (TIMEOUT_CYCLES is used only then).

module pid_share_arbiter #(
  parameter int  NUM_CH         = 4,
  parameter int  WIDTH          = 16,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_CH)
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic [NUM_CH-1:0]       in_req,
  input  logic [NUM_CH*WIDTH-1:0] in_err_bus,
  output logic [NUM_CH-1:0]       out_ack,
  output logic [WIDTH-1:0]        out_usign_out,
  output logic                    out_sign,
  output logic                    out_fail,
  output logic                    out_pid_start,
  output logic [WIDTH-1:0]        out_pid_err,
  output logic [ID_W-1:0]         out_pid_ch,
  input  logic                    in_pid_done,
  input  logic [WIDTH-1:0]        in_pid_usign_out,
  input  logic                    in_pid_sign,
  output logic                    out_busy,
  output logic                    out_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  pid_ch_q, pid_ch_d;
  logic [WIDTH-1:0] pid_err_q, pid_err_d;
  logic [WIDTH-1:0] usign_q, usign_d;
  logic             sign_q, sign_d;

  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] grant_err;

`ifdef PID_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
`endif

  // Search starts one past the last winner, so the previous grantee has lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    cand        = last_grant_q;
    grant_err   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = last_grant_q + ID_W'(i);
      if (!grant_valid && in_req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == ID_W'(k)) grant_err = in_err_bus[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pid_ch_d     = pid_ch_q;
    pid_err_d    = pid_err_q;
    usign_d      = usign_q;
    sign_d       = sign_q;
`ifdef PID_ARB_TIMEOUT_EN
    run_cnt_d    = run_cnt_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = ST_RUN;
          last_grant_d = grant_idx;
          pid_ch_d     = grant_idx;
          pid_err_d    = grant_err;
`ifdef PID_ARB_TIMEOUT_EN
          run_cnt_d    = '0;
`endif
        end
      end
      ST_RUN: begin
        // A done and a watchdog expiry in the same cycle resolve in favour of the real result.
        if (in_pid_done) begin
          usign_d = in_pid_usign_out;
          sign_d  = in_pid_sign;
          state_d = ST_RESP;
`ifdef PID_ARB_TIMEOUT_EN
          fail_d  = 1'b0;
`endif
        end
`ifdef PID_ARB_TIMEOUT_EN
        else if (run_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          usign_d   = '0;
          sign_d    = 1'b0;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // last_grant resets to the top channel so channel 0 wins the first arbitration.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_CH - 1);
      pid_ch_q     <= '0;
      pid_err_q    <= '0;
      usign_q      <= '0;
      sign_q       <= 1'b0;
`ifdef PID_ARB_TIMEOUT_EN
      run_cnt_q    <= '0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pid_ch_q     <= pid_ch_d;
      pid_err_q    <= pid_err_d;
      usign_q      <= usign_d;
      sign_q       <= sign_d;
`ifdef PID_ARB_TIMEOUT_EN
      run_cnt_q    <= run_cnt_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  always_comb begin
    out_ack = '0;
    if (state_q == ST_RESP) out_ack[pid_ch_q] = 1'b1;
  end

  assign out_pid_start = (state_q == ST_RUN);
  assign out_busy      = (state_q != ST_IDLE);
  assign out_pid_err   = pid_err_q;
  assign out_pid_ch    = pid_ch_q;
  assign out_usign_out = usign_q;
  assign out_sign      = sign_q;

`ifdef PID_ARB_TIMEOUT_EN
  assign out_fail      = fail_q;
  assign out_timeout   = timeout_q;
`else
  assign out_fail      = 1'b0;
  assign out_timeout   = 1'b0;
`endif

endmodule
